// File: rtl/rle_decompressor.sv
// Run-length expander: buffers (data, count) pairs in a small FIFO and replays each
// symbol count times over a valid/ready output. Define RLE_STATS_EN for pair/byte counters.
module rle_decompressor #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              overflow
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]       stat_pairs,
  output logic [15:0]       stat_bytes
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  fifo_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    occupancy;
  logic              fifo_full, fifo_empty;
  logic              push, pop, transfer;
  logic [CNT_W-1:0]  remaining, remaining_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;

  assign fifo_full  = (occupancy == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (occupancy == '0);
  assign in_ready   = !fifo_full;
  assign push       = valid_in && in_ready && (count_in != '0);
  assign transfer   = valid_out && out_ready;

  // Storage needs no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= data_in;
      fifo_cnt[wr_ptr]  <= count_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (valid_in && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_out  <= '0;
      valid_out <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      remaining <= remaining_nxt;
    end
  end

  // The last byte of a run loads the next pair on the same edge so back-to-back runs have no bubble.
  always_comb begin
    state_nxt     = state;
    data_nxt      = data_out;
    valid_nxt     = valid_out;
    remaining_nxt = remaining;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          data_nxt      = fifo_data[rd_ptr];
          remaining_nxt = fifo_cnt[rd_ptr];
          valid_nxt     = 1'b1;
          state_nxt     = EMIT;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (remaining > CNT_W'(1)) begin
            remaining_nxt = remaining - 1'b1;
          end else if (!fifo_empty) begin
            pop           = 1'b1;
            data_nxt      = fifo_data[rd_ptr];
            remaining_nxt = fifo_cnt[rd_ptr];
          end else begin
            valid_nxt     = 1'b0;
            remaining_nxt = '0;
            state_nxt     = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RLE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pairs <= '0;
      stat_bytes <= '0;
    end else begin
      if (push && stat_pairs != 16'hFFFF)     stat_pairs <= stat_pairs + 1'b1;
      if (transfer && stat_bytes != 16'hFFFF) stat_bytes <= stat_bytes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_decompressor.sv
// Bench for rle_decompressor: table-driven pair pushes feeding a byte scoreboard,
// plus hand-written stall, overflow, long-run and mid-run reset sequences.
module tb_rle_decompressor;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
    logic       expReady;
    logic       expValid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] count_in = '0;
  logic       valid_in = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       out_ready = 1'b0;
  logic       overflow;
`ifdef RLE_STATS_EN
  logic [15:0] stat_pairs, stat_bytes;
`endif

  int         checks = 0;
  int         errors = 0;
  int         xferCount = 0;
  logic [7:0] expQ[$];
  logic       noBubble = 1'b0;
  logic       inBurst = 1'b0;
  vec_t       vecs[11];

  rle_decompressor #(.DATA_W(8), .CNT_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .count_in(count_in),
    .valid_in(valid_in), .in_ready(in_ready), .data_out(data_out),
    .valid_out(valid_out), .out_ready(out_ready), .overflow(overflow)
`ifdef RLE_STATS_EN
    , .stat_pairs(stat_pairs), .stat_bytes(stat_bytes)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: called at the falling edge, when a transfer is about to happen.
  task automatic monitor();
    logic [7:0] exp;
    if (!rst_n) return;
    if (noBubble && inBurst && expQ.size() > 0 && out_ready)
      checkOutput("no_bubble_valid", 32'(valid_out), 32'd1);
    if (valid_out && out_ready) begin
      xferCount++;
      inBurst = 1'b1;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        exp = expQ.pop_front();
        checkOutput("byte_data", 32'(data_out), 32'(exp));
      end
      if (expQ.size() == 0) inBurst = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      data_in  = vecs[i].data;
      count_in = vecs[i].cnt;
      valid_in = 1'b1;
      checkOutput($sformatf("in_ready_row%0d", i), 32'(in_ready), 32'(vecs[i].expReady));
      if (vecs[i].expReady && vecs[i].cnt != 0)
        for (int k = 0; k < int'(vecs[i].cnt); k++) expQ.push_back(vecs[i].data);
      tick();
      valid_in = 1'b0;
      checkOutput($sformatf("valid_out_row%0d", i), 32'(valid_out), 32'(vecs[i].expValid));
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_left", 32'(expQ.size()), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    expQ.delete();
    inBurst = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0]  = '{8'h41, 8'd4, 1'b1, 1'b0};
    vecs[1]  = '{8'h42, 8'd2, 1'b1, 1'b1};
    vecs[2]  = '{8'h43, 8'd1, 1'b1, 1'b1};
    vecs[3]  = '{8'hAA, 8'd0, 1'b1, 1'b0};
    vecs[4]  = '{8'hBB, 8'd2, 1'b1, 1'b0};
    vecs[5]  = '{8'h10, 8'd1, 1'b1, 1'b0};
    vecs[6]  = '{8'h11, 8'd1, 1'b1, 1'b1};
    vecs[7]  = '{8'h12, 8'd1, 1'b1, 1'b1};
    vecs[8]  = '{8'h13, 8'd1, 1'b1, 1'b1};
    vecs[9]  = '{8'h14, 8'd1, 1'b1, 1'b1};
    vecs[10] = '{8'h15, 8'd1, 1'b0, 1'b1};

    #2;
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    doReset();

    $display("[TB] three consecutive runs");
    out_ready = 1'b1;
    noBubble  = 1'b1;
    applyStimulus(0, 2);
    waitDrain(40);
    checkOutput("t1_valid_after", 32'(valid_out), 32'd0);
    checkOutput("t1_overflow", 32'(overflow), 32'd0);
    noBubble = 1'b0;

    $display("[TB] stall handling");
    out_ready = 1'b0;
    data_in = 8'h55; count_in = 8'd3; valid_in = 1'b1;
    expQ.push_back(8'h55); expQ.push_back(8'h55); expQ.push_back(8'h55);
    tick();
    valid_in = 1'b0;
    tick();
    begin
      logic [4:0] pattern = 5'b11001;
      for (int i = 0; i < 5; i++) begin
        out_ready = pattern[i];
        checkOutput($sformatf("t2_valid_%0d", i), 32'(valid_out), 32'd1);
        checkOutput($sformatf("t2_data_%0d", i), 32'(data_out), 32'h55);
        tick();
      end
    end
    checkOutput("t2_valid_after", 32'(valid_out), 32'd0);
    checkOutput("t2_left", 32'(expQ.size()), 32'd0);

    $display("[TB] zero-count run");
    doReset();
    out_ready = 1'b1;
    applyStimulus(3, 4);
    waitDrain(20);
    tick();
    checkOutput("t3_valid_after", 32'(valid_out), 32'd0);
`ifdef RLE_STATS_EN
    checkOutput("t3_stat_pairs", 32'(stat_pairs), 32'd1);
    checkOutput("t3_stat_bytes", 32'(stat_bytes), 32'd2);
`endif

    $display("[TB] fill and overflow");
    out_ready = 1'b0;
    applyStimulus(5, 10);
    checkOutput("t4_overflow_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    waitDrain(40);
    tick();
    checkOutput("t4_valid_after", 32'(valid_out), 32'd0);
    checkOutput("t4_overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] maximum run");
    doReset();
    out_ready = 1'b1;
    noBubble  = 1'b1;
    data_in = 8'h7E; count_in = 8'd255; valid_in = 1'b1;
    for (int k = 0; k < 255; k++) expQ.push_back(8'h7E);
    xferCount = 0;
    tick();
    valid_in = 1'b0;
    waitDrain(300);
    checkOutput("t5_count", 32'(xferCount), 32'd255);
    checkOutput("t5_valid_after", 32'(valid_out), 32'd0);
    noBubble = 1'b0;

    $display("[TB] reset mid-run");
    doReset();
    out_ready = 1'b1;
    data_in = 8'h66; count_in = 8'd10; valid_in = 1'b1;
    for (int k = 0; k < 10; k++) expQ.push_back(8'h66);
    xferCount = 0;
    tick();
    valid_in = 1'b0;
    begin
      int n = 0;
      while (xferCount < 3 && n < 20) begin
        tick();
        n++;
      end
    end
    checkOutput("t6_xfers_before_reset", 32'(xferCount), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid_in_reset", 32'(valid_out), 32'd0);
    checkOutput("t6_data_in_reset", 32'(data_out), 32'd0);
    checkOutput("t6_ready_in_reset", 32'(in_ready), 32'd1);
    expQ.delete();
    inBurst = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    checkOutput("t6_valid_after_release", 32'(valid_out), 32'd0);
    checkOutput("t6_overflow_after_release", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
